// File: rtl/misr_signature_unit.sv
// -----------------------------------------------------------------------------
// misr_signature_unit
//
// Multiple-input signature register (MISR) with a small session controller.
//
// In IDLE the register is driven directly by `mode`:
//   00 hold, 01 compress din when din_valid, 10 serial scan shift, 11 seed load.
// A `start` pulse in IDLE opens a counted session instead. The session
// compresses exactly `len` valid beats, then spends one CHECK cycle in which
// the signature is compared against `expected`. The result is latched on
// `pass`.
//
// Parameters
//   WIDTH  signature / data width (4..32)
//   POLY   feedback taps; bit i set means the feedback is XORed into stage i
//   SEED   signature value after reset
//   CNT_W  width of the session length counter
//
// Ports
//   Clk        clock; all state changes on its rising edge
//   reset      synchronous, active-high reset
//   mode       IDLE-state operation select
//   din        parallel response data to compress
//   din_valid  qualifies din
//   seed       value loaded by mode 11
//   sgi        scan serial input
//   sgo        scan serial output (MSB while scanning in IDLE, else 0)
//   start      begins a counted session (ignored while busy)
//   len        number of valid beats in the session
//   expected   golden signature compared in CHECK
//   signature  current register value
//   busy       high in RUN or CHECK
//   done       high for exactly the CHECK cycle
//   pass       result of the last comparison
// -----------------------------------------------------------------------------
module misr_signature_unit #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = 16'h1021,
   parameter logic [WIDTH-1:0] SEED  = '0,
   parameter int               CNT_W = 16
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic [WIDTH-1:0] seed,
   input  logic             sgi,
   output logic             sgo,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [WIDTH-1:0] expected,
   output logic [WIDTH-1:0] signature,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   localparam logic [1:0] M_HOLD = 2'b00;
   localparam logic [1:0] M_COMP = 2'b01;
   localparam logic [1:0] M_SCAN = 2'b10;
   localparam logic [1:0] M_LOAD = 2'b11;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   logic [WIDTH-1:0] sig;
   logic [CNT_W-1:0] cnt;
   logic             pass_q;

   logic [WIDTH-1:0] sig_comp;
   logic [WIDTH-1:0] sig_scan;
   logic             last_beat;

   // Next-value candidates for the two shift operations.
   always_comb begin
      sig_comp = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
      sig_scan = {sig[WIDTH-2:0], sgi};
   end

   // The beat that consumes the final remaining count. Checking for 1 rather
   // than decrementing past zero keeps the full CNT_W range usable:
   // len = 2^CNT_W-1 compresses exactly that many beats with no wrap.
   assign last_beat = (cnt == CNT_ONE);

   always_ff @(posedge Clk) begin
      if (reset) begin
         state  <= S_IDLE;
         sig    <= SEED;
         cnt    <= '0;
         pass_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  // Session open: signature is left as-is so a prior seed
                  // load or scan-in becomes the session's starting value.
                  pass_q <= 1'b0;
                  cnt    <= len;
                  state  <= (len == '0) ? S_CHECK : S_RUN;
               end else begin
                  case (mode)
                     M_HOLD: sig <= sig;
                     M_COMP: if (din_valid) sig <= sig_comp;
                     M_SCAN: sig <= sig_scan;
                     M_LOAD: sig <= seed;
                     default: sig <= sig;
                  endcase
               end
            end

            S_RUN: begin
               // mode and start are ignored; only valid beats advance.
               if (din_valid) begin
                  sig <= sig_comp;
                  cnt <= cnt - CNT_ONE;
                  if (last_beat) state <= S_CHECK;
               end
            end

            S_CHECK: begin
               pass_q <= (sig == expected);
               state  <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign signature = sig;
   assign pass      = pass_q;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_CHECK);

   // Serial out is only meaningful while scanning; forced low during reset.
   assign sgo = (!reset && state == S_IDLE && mode == M_SCAN) ? sig[WIDTH-1] : 1'b0;

endmodule

// File: tb/tb_misr_signature_unit.sv
module tb_misr_signature_unit;

   localparam int W = 4;
   localparam int C = 4;

   logic         Clk = 1'b0;
   logic         reset;
   logic [1:0]   mode;
   logic [W-1:0] din;
   logic         din_valid;
   logic [W-1:0] seed;
   logic         sgi;
   logic         sgo;
   logic         start;
   logic [C-1:0] len;
   logic [W-1:0] expected;
   logic [W-1:0] signature;
   logic         busy;
   logic         done;
   logic         pass;

   int n_checks = 0;
   int n_fail   = 0;

   misr_signature_unit #(
      .WIDTH (W),
      .POLY  (4'h3),
      .SEED  (4'h0),
      .CNT_W (C)
   ) dut (
      .Clk       (Clk),
      .reset     (reset),
      .mode      (mode),
      .din       (din),
      .din_valid (din_valid),
      .seed      (seed),
      .sgi       (sgi),
      .sgo       (sgo),
      .start     (start),
      .len       (len),
      .expected  (expected),
      .signature (signature),
      .busy      (busy),
      .done      (done),
      .pass      (pass)
   );

   always #5 Clk = ~Clk;

   // Reference compress: multiply by x modulo the feedback polynomial,
   // then add the incoming data word (all in GF(2), done with integers).
   function automatic logic [W-1:0] ref_comp(input logic [W-1:0] s, input logic [W-1:0] d);
      int v;
      v = (int'(s) * 2) % 16;
      if (int'(s) >= 8) v = v ^ 3;
      return 4'(v) ^ d;
   endfunction

   function automatic logic [W-1:0] ref_fold(input logic [W-1:0] s0, input logic [W-1:0] beats[$]);
      logic [W-1:0] s;
      s = s0;
      foreach (beats[i]) s = ref_comp(s, beats[i]);
      return s;
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle_inputs();
      mode = 2'b00; din = '0; din_valid = 1'b0; seed = '0; sgi = 1'b0;
      start = 1'b0; len = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      expected = '0;
      do_reset();
      n_checks++;
      if (signature !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || sgo !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: sig=%h busy=%b done=%b pass=%b sgo=%b, want 0 0 0 0 0",
                  signature, busy, done, pass, sgo);
      end
   endtask

   // Starts a 5-beat session with beats 1,0,0,0,0, optional stalls after beat 2.
   task automatic run_ref_session(input int stalls, input logic [W-1:0] exp_val, input string tag);
      logic [W-1:0] want_sig [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
      int cyc;
      do_reset();
      expected = exp_val;
      start = 1'b1; len = 4'd5;
      step(); cyc = 1;
      start = 1'b0;
      for (int b = 0; b < 5; b++) begin
         if (b == 2) begin
            for (int s = 0; s < stalls; s++) begin
               din_valid = 1'b0; din = 4'hF;
               step(); cyc++;
               n_checks++;
               if (signature !== 4'h2 || done !== 1'b0 || busy !== 1'b1) begin
                  n_fail++;
                  $display("FAIL %s_stall: sig=%h done=%b busy=%b, want 2 0 1", tag, signature, done, busy);
               end
            end
         end
         din_valid = 1'b1; din = (b == 0) ? 4'h1 : 4'h0;
         step(); cyc++;
         n_checks++;
         if (signature !== want_sig[b] || done !== (b == 4)) begin
            n_fail++;
            $display("FAIL %s_beat%0d: sig=%h done=%b, want %h %b", tag, b, signature, done, want_sig[b], b == 4);
         end
      end
      din_valid = 1'b0;
      n_checks++;
      if (cyc !== 6 + stalls) begin
         n_fail++;
         $display("FAIL %s_done_latency: %0d, want %0d", tag, cyc, 6 + stalls);
      end
      step();
      n_checks++;
      if (pass !== (exp_val == 4'h3) || done !== 1'b0 || busy !== 1'b0 || signature !== 4'h3) begin
         n_fail++;
         $display("FAIL %s_result: pass=%b done=%b busy=%b sig=%h, want %b 0 0 3",
                  tag, pass, done, busy, signature, exp_val == 4'h3);
      end
   endtask

   task automatic test_counted_run();
      run_ref_session(0, 4'h3, "counted");
   endtask

   task automatic test_stalls();
      run_ref_session(3, 4'h3, "stalls");
   endtask

   task automatic test_mismatch();
      run_ref_session(0, 4'h5, "mismatch");
   endtask

   task automatic test_scan();
      logic [3:0] want_sgo = 4'b1010;
      do_reset();
      mode = 2'b11; seed = 4'hA;
      step();
      n_checks++;
      if (signature !== 4'hA) begin
         n_fail++;
         $display("FAIL scan_seed: sig=%h, want a", signature);
      end
      mode = 2'b10; sgi = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (sgo !== want_sgo[3-i]) begin
            n_fail++;
            $display("FAIL scan_sgo%0d: sgo=%b, want %b", i, sgo, want_sgo[3-i]);
         end
         step();
      end
      n_checks++;
      if (signature !== 4'h0) begin
         n_fail++;
         $display("FAIL scan_final: sig=%h, want 0", signature);
      end
      mode = 2'b00;
      #1;
      n_checks++;
      if (sgo !== 1'b0) begin
         n_fail++;
         $display("FAIL scan_sgo_off: sgo=%b, want 0", sgo);
      end
   endtask

   task automatic test_len_zero();
      for (int k = 0; k < 2; k++) begin
         do_reset();
         mode = 2'b11; seed = 4'h6;
         step();
         mode = 2'b00;
         expected = (k == 0) ? 4'h6 : 4'h7;
         start = 1'b1; len = '0;
         step();
         start = 1'b0;
         n_checks++;
         if (done !== 1'b1 || busy !== 1'b1 || signature !== 4'h6) begin
            n_fail++;
            $display("FAIL len0_check%0d: done=%b busy=%b sig=%h, want 1 1 6", k, done, busy, signature);
         end
         step();
         n_checks++;
         if (pass !== (k == 0) || done !== 1'b0 || signature !== 4'h6) begin
            n_fail++;
            $display("FAIL len0_pass%0d: pass=%b done=%b sig=%h, want %b 0 6", k, pass, done, signature, k == 0);
         end
      end
   endtask

   task automatic test_start_during_run();
      logic [W-1:0] beats[$] = '{4'h5, 4'h9, 4'hC};
      logic [W-1:0] want;
      do_reset();
      want = ref_fold(4'h0, beats);
      expected = want;
      start = 1'b1; len = 4'd3;
      step();
      for (int b = 0; b < 3; b++) begin
         // start held high with a different len and a busy mode: all ignored
         start = (b < 2); len = 4'd9; mode = 2'b11; seed = 4'hF;
         din_valid = 1'b1; din = beats[b];
         step();
         n_checks++;
         if (done !== (b == 2) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun_beat%0d: done=%b busy=%b, want %b 1", b, done, busy, b == 2);
         end
      end
      start = 1'b0; din_valid = 1'b0; mode = 2'b00;
      n_checks++;
      if (signature !== want) begin
         n_fail++;
         $display("FAIL rerun_sig: %h, want %h", signature, want);
      end
      step();
      n_checks++;
      if (pass !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rerun_pass: pass=%b busy=%b, want 1 0", pass, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      // Leave pass=1 behind so reset is seen clearing it.
      expected = 4'h0;
      start = 1'b1; len = '0;
      step(); start = 1'b0; step();
      start = 1'b1; len = 4'd5; expected = 4'h3;
      step();
      start = 1'b0;
      din_valid = 1'b1; din = 4'h1; step();
      din = 4'h0; step();
      reset = 1'b1; start = 1'b1; mode = 2'b10; din_valid = 1'b1; din = 4'h7;
      #1;
      n_checks++;
      if (sgo !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_sgo_during: sgo=%b, want 0", sgo);
      end
      step();
      n_checks++;
      if (signature !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_run: sig=%h busy=%b done=%b pass=%b, want 0 0 0 0",
                  signature, busy, done, pass);
      end
      reset = 1'b0; idle_inputs();
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after%0d: done=%b busy=%b, want 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_max_len();
      logic [W-1:0] beats[$];
      logic [W-1:0] want;
      do_reset();
      for (int i = 0; i < 15; i++) beats.push_back(4'($urandom_range(0, 15)));
      want = ref_fold(4'h0, beats);
      expected = want;
      start = 1'b1; len = 4'hF;
      step();
      start = 1'b0;
      for (int b = 0; b < 15; b++) begin
         din_valid = 1'b1; din = beats[b];
         step();
         n_checks++;
         if (done !== (b == 14) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL maxlen_beat%0d: done=%b busy=%b, want %b 1", b, done, busy, b == 14);
         end
      end
      din_valid = 1'b0;
      step();
      n_checks++;
      if (signature !== want || pass !== 1'b1) begin
         n_fail++;
         $display("FAIL maxlen_result: sig=%h pass=%b, want %h 1", signature, pass, want);
      end
   endtask

   // Random IDLE operations interleaved with random sessions, checked against
   // a session-level model (beats folded through ref_comp).
   task automatic test_random();
      logic [W-1:0] m_sig;
      logic         m_pass;
      logic [W-1:0] beats[$];
      logic [W-1:0] want;
      int           n_beats;
      do_reset();
      m_sig = 4'h0; m_pass = 1'b0;
      for (int it = 0; it < 40; it++) begin
         for (int c = 0; c < int'($urandom_range(1, 5)); c++) begin
            mode = 2'($urandom); din = 4'($urandom); din_valid = 1'($urandom);
            seed = 4'($urandom); sgi = 1'($urandom); start = 1'b0;
            #1;
            n_checks++;
            if (sgo !== ((mode == 2'b10) ? m_sig[3] : 1'b0)) begin
               n_fail++;
               $display("FAIL rnd_sgo it%0d: sgo=%b mode=%b, want %b", it, sgo, mode,
                        (mode == 2'b10) ? m_sig[3] : 1'b0);
            end
            case (mode)
               2'b01: if (din_valid) m_sig = ref_comp(m_sig, din);
               2'b10: m_sig = {m_sig[2:0], sgi};
               2'b11: m_sig = seed;
               default: ;
            endcase
            step();
            n_checks++;
            if (signature !== m_sig || pass !== m_pass || busy !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_idle it%0d: sig=%h pass=%b busy=%b, want %h %b 0",
                        it, signature, pass, busy, m_sig, m_pass);
            end
         end
         n_beats = $urandom_range(0, 6);
         beats.delete();
         for (int b = 0; b < n_beats; b++) beats.push_back(4'($urandom));
         want = ref_fold(m_sig, beats);
         expected = ($urandom_range(0, 1) == 1) ? want : 4'($urandom);
         start = 1'b1; len = 4'(n_beats); din_valid = 1'b0;
         step();
         start = 1'b0;
         for (int b = 0; b < n_beats; b++) begin
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
               din_valid = 1'b0; din = 4'($urandom); mode = 2'($urandom);
               start = 1'($urandom);
               step();
            end
            din_valid = 1'b1; din = beats[b]; mode = 2'($urandom); start = 1'b0;
            step();
         end
         din_valid = 1'b0; start = 1'b0;
         n_checks++;
         if (done !== 1'b1 || signature !== want) begin
            n_fail++;
            $display("FAIL rnd_check it%0d: done=%b sig=%h, want 1 %h", it, done, signature, want);
         end
         m_sig  = want;
         m_pass = (want == expected);
         step();
         n_checks++;
         if (pass !== m_pass || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_pass it%0d: pass=%b done=%b busy=%b, want %b 0 0",
                     it, pass, done, busy, m_pass);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      expected = '0;
      idle_inputs();
      test_reset();
      test_counted_run();
      test_stalls();
      test_mismatch();
      test_scan();
      test_len_zero();
      test_start_during_run();
      test_reset_mid_run();
      test_max_len();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/misr_signature_unit.md
MISR_SIGNATURE_UNIT -- requirements
Module: misr_signature_unit

Interface
Parameters:
REQ-001 SHALL have parameter WIDTH, default 16: signature and data width, legal range 4..32.
REQ-002 SHALL have parameter POLY, default 16'h1021: feedback taps, WIDTH bits, bit i set means tap into stage i.
REQ-003 SHALL have parameter SEED, default 0: signature value after reset.
REQ-004 SHALL have parameter CNT_W, default 16: width of the session length.
Ports:
REQ-005 SHALL have port Clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port mode, input, 2 bits: IDLE-state operation; 00 hold, 01 free compress, 10 scan shift, 11 seed load.
REQ-008 SHALL have port din, input, WIDTH bits: parallel response data to compress.
REQ-009 SHALL have port din_valid, input, 1 bit: qualifies din.
REQ-010 SHALL have port seed, input, WIDTH bits: value loaded by mode 11.
REQ-011 SHALL have port sgi, input, 1 bit: scan serial input.
REQ-012 SHALL have port sgo, output, 1 bit: scan serial output.
REQ-013 SHALL have port start, input, 1 bit: begins a counted session.
REQ-014 SHALL have port len, input, CNT_W bits: number of valid beats in the session.
REQ-015 SHALL have port expected, input, WIDTH bits: golden signature.
REQ-016 SHALL have port signature, output, WIDTH bits: current register value.
REQ-017 SHALL have port busy, output, 1 bit: high in RUN or CHECK.
REQ-018 SHALL have port done, output, 1 bit: high for exactly the CHECK cycle.
REQ-019 SHALL have port pass, output, 1 bit: result of the last comparison.

Function
REQ-020 Compress step SHALL be: fb = sig[WIDTH-1]; sig <= {sig[WIDTH-2:0],0} XOR (fb ? POLY : 0) XOR din.
REQ-021 Scan step SHALL be: sig <= {sig[WIDTH-2:0], sgi}.
REQ-022 sgo SHALL equal sig[WIDTH-1] when state is IDLE and mode is 10, and SHALL be 0 otherwise.
REQ-023 FSM SHALL have exactly three states: IDLE, RUN and CHECK.
REQ-024 In IDLE with start=0, SHALL act on mode as follows:
- 00: hold.
- 01: compress when din_valid=1, otherwise hold.
- 10: scan step every cycle.
- 11: sig <= seed.
REQ-025 In IDLE, start=1 SHALL take priority over mode:
- sig unchanged.
- pass <= 0.
- remaining count <= len.
- next state RUN, or CHECK when len=0.
REQ-026 In RUN, mode SHALL be ignored and compress SHALL occur only on din_valid=1, each decrementing the count.
- The beat bringing the count to 0 SHALL move the FSM to CHECK.
REQ-027 In RUN with din_valid=0, sig and the count SHALL hold.
REQ-028 CHECK SHALL last one cycle:
- done=1 and sig holds.
- At the CHECK edge, pass <= (sig == expected) and state <= IDLE.
REQ-029 pass SHALL hold its value until the next accepted start or reset.
REQ-030 start while busy SHALL be ignored.
REQ-031 din_valid SHALL have no effect in IDLE unless mode is 01.
REQ-032 The count SHALL be CNT_W bits with no wrap: len = 2^CNT_W - 1 SHALL compress exactly that many beats.
REQ-033 busy SHALL equal (state != IDLE); done SHALL equal (state == CHECK); both are outputs of registered state only.

Reset
REQ-034 reset=1 at a rising edge SHALL force, from any state including mid-RUN and CHECK:
- state IDLE, sig = SEED, count = 0.
- pass = 0, busy = 0, done = 0, sgo = 0.
REQ-035 reset SHALL override start, mode and din_valid in the same cycle.

Verification (WIDTH=4, POLY=4'h3, SEED=0)
REQ-036 Counted run: reset; start with len=5; din beats 1,0,0,0,0 -> signature 1,2,4,8,3.
- done high the cycle after the 5th beat; expected=3 -> pass=1.
REQ-037 Stalls: same as REQ-036 with din_valid=0 for 3 cycles between beats 2 and 3 -> identical final signature 3.
- done delayed by 3 cycles.
REQ-038 Scan: mode 11 with seed=4'hA, then mode 10 with sgi=0 for 4 cycles -> sgo = 1,0,1,0; signature=0.
REQ-039 Edge cases:
- len=0 -> CHECK on the next cycle; signature unchanged; pass=(sig==expected).
- start during RUN -> ignored.
REQ-040 Reset mid-RUN after 2 beats -> next cycle signature=0, busy=0, done never asserts.
- Mismatch case: expected=4'h5 with REQ-036 stimulus -> pass=0.
